// File: rtl/reg_file.sv
// ============================================================================
// reg_file : DEPTH x WIDTH register file, one write port, two registered reads
// Rev 1.0
// ============================================================================
`default_nettype none

module reg_file #(
   parameter int WIDTH   = 4,
   parameter int DEPTH   = 8,
   parameter int ADDR_W  = 3,
   parameter bit BYPASS  = 1'b1,
   parameter bit ZERO_R0 = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr_a,
   output logic [WIDTH-1:0]  rdata_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [WIDTH-1:0]  rdata_b,
   output logic              wr_err
);

   // One extra bit so DEPTH == 2**ADDR_W is representable.
   localparam logic [ADDR_W:0] c_depth_ext = (ADDR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
   logic [WIDTH-1:0] rdata_b_q, rdata_b_d;
   logic             wr_err_q, wr_err_d;

   logic             w_wr_ok;

   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < c_depth_ext) && !(ZERO_R0 && (a == '0));
   endfunction

   assign w_wr_ok = we && !clr && addr_ok(waddr);

   always_comb begin
      wr_err_d = we && !clr && !addr_ok(waddr);

      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
         if (clr) begin
            mem_d[i] = '0;
         end else if (w_wr_ok && ({1'b0, waddr} == (ADDR_W + 1)'(i))) begin
            mem_d[i] = wdata;
         end
      end

      // Unmapped and hard-zero addresses fall through to the zero default.
      rdata_a_d = '0;
      if (!clr && addr_ok(raddr_a)) begin
         for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, raddr_a} == (ADDR_W + 1)'(i)) begin
               rdata_a_d = mem_q[i];
            end
         end
         if (BYPASS && w_wr_ok && (waddr == raddr_a)) begin
            rdata_a_d = wdata;
         end
      end

      rdata_b_d = '0;
      if (!clr && addr_ok(raddr_b)) begin
         for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, raddr_b} == (ADDR_W + 1)'(i)) begin
               rdata_b_d = mem_q[i];
            end
         end
         if (BYPASS && w_wr_ok && (waddr == raddr_b)) begin
            rdata_b_d = wdata;
         end
      end
   end

   generate
      for (genvar g = 0; g < DEPTH; g++) begin : g_entry
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               mem_q[g] <= '0;
            end else begin
               mem_q[g] <= mem_d[g];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_a_q <= '0;
         rdata_b_q <= '0;
         wr_err_q  <= 1'b0;
      end else begin
         rdata_a_q <= rdata_a_d;
         rdata_b_q <= rdata_b_d;
         wr_err_q  <= wr_err_d;
      end
   end

   assign rdata_a = rdata_a_q;
   assign rdata_b = rdata_b_q;
   assign wr_err  = wr_err_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_file.sv
// ============================================================================
// tb_reg_file : scoreboard bench for reg_file, two parameterisations side by side
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_reg_file;

   localparam int WIDTH  = 4;
   localparam int DEPTH  = 6;
   localparam int ADDR_W = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              clr = 1'b0;
   logic              we = 1'b0;
   logic [ADDR_W-1:0] waddr = '0;
   logic [WIDTH-1:0]  wdata = '0;
   logic [ADDR_W-1:0] raddr_a = '0;
   logic [ADDR_W-1:0] raddr_b = '0;

   logic [WIDTH-1:0]  ra0, rb0, ra1, rb1;
   logic              e0, e1;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // dut0: bypass on, entry 0 writable; dut1: bypass off, entry 0 hard zero
   reg_file #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BYPASS(1'b1), .ZERO_R0(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr_a(raddr_a), .rdata_a(ra0), .raddr_b(raddr_b), .rdata_b(rb0), .wr_err(e0)
   );

   reg_file #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BYPASS(1'b0), .ZERO_R0(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr_a(raddr_a), .rdata_a(ra1), .raddr_b(raddr_b), .rdata_b(rb1), .wr_err(e1)
   );

   typedef struct {
      logic [WIDTH-1:0] a0, b0, a1, b1;
      logic             e0, e1;
   } exp_t;

   exp_t sbq[$];

   // Reference contents for model 0 (dut0) and model 1 (dut1)
   logic [WIDTH-1:0] mem [2][DEPTH];

   function automatic bit legal(int m, int a);
      return (a < DEPTH) && !((m == 1) && (a == 0));
   endfunction

   function automatic logic [WIDTH-1:0] model_read(int m, int a, bit wv);
      if (clr || !legal(m, a)) return '0;
      if ((m == 0) && wv && (a == int'(waddr))) return wdata;
      return mem[m][a];
   endfunction

   task automatic model_clear();
      for (int m = 0; m < 2; m++)
         for (int k = 0; k < DEPTH; k++) mem[m][k] = '0;
   endtask

   task automatic model_step(output exp_t e);
      logic [WIDTH-1:0] ra [2];
      logic [WIDTH-1:0] rb [2];
      bit               er [2];
      for (int m = 0; m < 2; m++) begin
         bit wv;
         wv    = we && !clr && legal(m, int'(waddr));
         er[m] = we && !clr && !legal(m, int'(waddr));
         ra[m] = model_read(m, int'(raddr_a), wv);
         rb[m] = model_read(m, int'(raddr_b), wv);
         if (clr) begin
            for (int k = 0; k < DEPTH; k++) mem[m][k] = '0;
         end else if (wv) begin
            mem[m][int'(waddr)] = wdata;
         end
      end
      e.a0 = ra[0]; e.b0 = rb[0]; e.e0 = er[0];
      e.a1 = ra[1]; e.b1 = rb[1]; e.e1 = er[1];
   endtask

   task automatic chk(string name, logic [WIDTH-1:0] act, logic [WIDTH-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic drive(bit w, int wa, int wd, int a, int b, bit c);
      exp_t e;
      @(negedge clk);
      we      = w;
      waddr   = ADDR_W'(wa);
      wdata   = WIDTH'(wd);
      raddr_a = ADDR_W'(a);
      raddr_b = ADDR_W'(b);
      clr     = c;
      model_step(e);
      sbq.push_back(e);
   endtask

   task automatic check_all_zero(string tag);
      chk({tag, "_a0"}, ra0, '0);
      chk({tag, "_b0"}, rb0, '0);
      chk({tag, "_e0"}, WIDTH'(e0), '0);
      chk({tag, "_a1"}, ra1, '0);
      chk({tag, "_b1"}, rb1, '0);
      chk({tag, "_e1"}, WIDTH'(e1), '0);
   endtask

   // Reset asserted between edges: outputs must clear without a clock
   task automatic pulse_reset();
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1 check_all_zero("rst_now");
      we  = 1'b0;
      clr = 1'b0;
      @(posedge clk);
      #2 check_all_zero("rst_hold");
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
   endtask

   function automatic int pick_addr();
      case ($urandom % 5)
         0:       return 0;
         1:       return DEPTH - 1;
         2:       return DEPTH;
         3:       return (1 << ADDR_W) - 1;
         default: return int'($urandom % (1 << ADDR_W));
      endcase
   endfunction

   // Monitor: outputs are presented every cycle, one pending expectation per edge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("rdata_a_byp", ra0, e.a0);
            chk("rdata_b_byp", rb0, e.b0);
            chk("wr_err_byp", WIDTH'(e0), WIDTH'(e.e0));
            chk("rdata_a_zr0", ra1, e.a1);
            chk("rdata_b_zr0", rb1, e.b1);
            chk("wr_err_zr0", WIDTH'(e1), WIDTH'(e.e1));
         end
      end
   end

   initial begin
      model_clear();
      #2 rst_n = 1'b0;
      #1 check_all_zero("rst_init");
      @(negedge clk);
      rst_n = 1'b1;

      // Fill 1..5, reset between edges, then every address reads 0
      for (int i = 1; i <= 5; i++) drive(1, i, i, 0, 0, 0);
      pulse_reset();
      for (int a = 0; a < 8; a++) drive(0, 0, 0, a, 7 - a, 0);

      // Plain write then read-back on both ports
      drive(1, 3, 'hA, 0, 0, 0);
      drive(0, 0, 0, 3, 3, 0);
      drive(0, 0, 0, 3, 3, 0);

      // Same-edge write and read of addr 5
      drive(1, 5, 2, 0, 0, 0);
      drive(1, 5, 7, 5, 5, 0);
      drive(0, 0, 0, 5, 5, 0);

      // Out-of-range write and reads
      drive(1, 6, 'hF, 7, 6, 0);
      drive(0, 0, 0, 7, 0, 0);
      drive(0, 0, 0, 5, 3, 0);

      // Write to entry 0
      drive(1, 0, 'hF, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);

      // Fill, clear colliding with a write, then write-back after clear
      for (int i = 0; i < DEPTH; i++) drive(1, i, i + 8, i, i, 0);
      drive(1, 2, 5, 2, 3, 1);
      for (int a = 0; a < DEPTH; a++) drive(0, 0, 0, a, a, 0);
      drive(1, 2, 5, 0, 0, 0);
      drive(0, 0, 0, 2, 2, 0);

      // Randomised traffic with boundary-biased addresses
      for (int n = 0; n < 600; n++) begin
         if (($urandom % 120) == 0) begin
            pulse_reset();
         end else begin
            drive(bit'($urandom % 2), pick_addr(), int'($urandom % 16),
                  pick_addr(), pick_addr(), (($urandom % 16) == 0));
         end
      end

      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (sbq.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", sbq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
